mouse_packet_encoder: RTL

MOUSE_PACKET_ENCODER -- requirements
Module: mouse_packet_encoder

---
 rtl/mouse_packet_encoder.sv | 67 ++++++
 1 files changed

// File: rtl/mouse_packet_encoder.sv
// mouse_packet_encoder: turns one button/delta report into a timed 3-byte PS/2-style packet
// (header, X, Y), each byte held for BYTE_GAP cycles with a STROBE_LEN-cycle mouseReady strobe.
module mouse_packet_encoder #(
    parameter int STROBE_LEN = 4,
    parameter int BYTE_GAP   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reqValid,
    output logic       reqReady,
    input  logic [9:0] reqDx,
    input  logic [9:0] reqDy,
    input  logic [2:0] reqButtons,
    output logic [7:0] mouseData,
    output logic       mouseReady,
    output logic       packetDone,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, HDR, XB, YB} state_t;
    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [7:0]  x_q, y_q, data_nxt;
    logic [9:0]  xs, ys;
    logic        slot_end;

    // {overflow, 9-bit two's complement value} clamped to -256..255
    function automatic logic [9:0] sat(input logic [9:0] d);
        return $signed(d) > 10'sd255 ? {1'b1, 9'h0FF} :
               $signed(d) < -10'sd256 ? {1'b1, 9'h100} : {1'b0, d[8:0]};
    endfunction

    assign xs         = sat(reqDx);
    assign ys         = sat(reqDy);
    assign slot_end   = cnt == 16'(BYTE_GAP - 1);
    assign reqReady   = state == IDLE;
    assign busy       = ~reqReady;
    assign mouseReady = state != IDLE && cnt < 16'(STROBE_LEN);

    always_comb begin
        state_nxt = state == IDLE ? (reqValid ? HDR : IDLE) :
                    !slot_end ? state :
                    state == YB ? IDLE : state_t'(state + 2'd1);
        data_nxt  = state == IDLE && reqValid ? {ys[9], xs[9], ys[8], xs[8], 1'b1, reqButtons} :
                    slot_end && state == HDR ? x_q :
                    slot_end && state == XB ? y_q : mouseData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            mouseData  <= '0;
            packetDone <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= (state_nxt != state || state == IDLE) ? '0 : cnt + 16'd1;
            packetDone <= state == YB && slot_end;
            mouseData  <= data_nxt;
            if (state == IDLE && reqValid) begin
                x_q <= xs[7:0];
                y_q <= ys[7:0];
            end
        end
    end
endmodule
